// File: rtl/tmr0_wdt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tmr0_wdt_ctrl_pkg
// Shared definitions for the TMR0 / watchdog control slice: power FSM
// encoding, OPTION register field positions and reset value, the default
// watchdog base period, and the prescaler terminal-mask helper.
// -----------------------------------------------------------------------------
package tmr0_wdt_ctrl_pkg;

    // OPTION register layout: {T0CS, T0SE, PSA, PS[2:0]}
    localparam int unsigned OPT_W      = 6;
    localparam int unsigned OPT_T0CS   = 5;
    localparam int unsigned OPT_T0SE   = 4;
    localparam int unsigned OPT_PSA    = 3;
    localparam int unsigned OPT_PS_MSB = 2;
    localparam int unsigned OPT_PS_LSB = 0;
    localparam int unsigned PS_W       = 3;

    localparam logic [OPT_W-1:0] OPTION_RST = 6'h3F;

    // Prescaler width and post-TMR0-write suppression length
    localparam int unsigned PSC_W     = 8;
    localparam int unsigned SUP_W     = 2;
    localparam int unsigned SUP_CYC   = 2;

    localparam int unsigned WDT_BASE_DEFAULT = 1024;

    // Power-state encoding
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SLP  = 2'd1,
        ST_WAKE = 2'd2
    } pwr_state_e;

    // Low-bit mask whose all-ones value marks the last count of a prescale
    // period: 2^(PS+1) when the prescaler serves TMR0, 2^PS when it serves
    // the watchdog.  Computed in 9 bits so PS=7 toward TMR0 yields 8'hFF.
    function automatic logic [PSC_W-1:0] psc_mask(input logic [PS_W-1:0] ps,
                                                  input logic            psa);
        logic [3:0] sh;
        logic [8:0] span;
        sh   = psa ? {1'b0, ps} : ({1'b0, ps} + 4'd1);
        span = 9'd1 << sh;
        return PSC_W'(span - 9'd1);
    endfunction

endpackage : tmr0_wdt_ctrl_pkg

// File: rtl/tmr0_wdt_ctrl_t0cki_sync.sv
// -----------------------------------------------------------------------------
// t0cki_sync
// Two-flop synchroniser for the asynchronous T0CKI pin followed by a one-flop
// history stage and a selectable edge detector.  A pin change shows up on
// edge_c in the cycle after the second synchroniser flop captures it.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   pin      in   asynchronous external clock pin
//   fall_sel in   0: detect rising edges, 1: detect falling edges
//   edge_c   out  combinational one-cycle edge indication
// -----------------------------------------------------------------------------
module t0cki_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    input  logic fall_sel,
    output logic edge_c
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    // Synchroniser chain plus history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign edge_c = fall_sel ? (~sync2_q & hist_q) : (sync2_q & ~hist_q);

endmodule : t0cki_sync

// File: rtl/tmr0_wdt_ctrl.sv
// -----------------------------------------------------------------------------
// tmr0_wdt_ctrl
// TMR0 increment source, shared 8-bit prescaler, watchdog base counter and
// the RUN/SLP/WAKE power FSM of a small PIC-style core.
//
// Ports
//   clk          in   system clock, one instruction cycle per rising edge
//   rst          in   synchronous active-high reset
//   option_wr    in   load OPTION from option_data
//   option_data  in   {T0CS, T0SE, PSA, PS[2:0]}
//   t0cki        in   asynchronous external TMR0 clock pin
//   tmr0_wr      in   register file writes TMR0 this cycle
//   wdt_en       in   watchdog enable fuse (static)
//   CLRWDT       in   CLRWDT instruction strobe
//   SLEEP        in   SLEEP instruction strobe
//   option_q     out  current OPTION value
//   tmr0_inc     out  one-cycle TMR0 increment pulse
//   wdtmr        out  one-cycle watchdog time-out pulse
//   sleeping     out  high in SLP and WAKE
//   wdt_rst_req  out  one-cycle core reset request on time-out while running
//   wake         out  one-cycle wake pulse on time-out while sleeping
// -----------------------------------------------------------------------------
module tmr0_wdt_ctrl
    import tmr0_wdt_ctrl_pkg::*;
#(
    parameter int unsigned WDT_BASE = WDT_BASE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             option_wr,
    input  logic [OPT_W-1:0] option_data,
    input  logic             t0cki,
    input  logic             tmr0_wr,
    input  logic             wdt_en,
    input  logic             CLRWDT,
    input  logic             SLEEP,
    output logic [OPT_W-1:0] option_q,
    output logic             tmr0_inc,
    output logic             wdtmr,
    output logic             sleeping,
    output logic             wdt_rst_req,
    output logic             wake
);

    localparam int unsigned               WDT_W   = $clog2(WDT_BASE);
    localparam logic [WDT_W-1:0]          WDT_MAX = WDT_W'(WDT_BASE - 1);

    pwr_state_e        state_q;
    pwr_state_e        state_nx;

    logic [PSC_W-1:0]  psc_q;
    logic [WDT_W-1:0]  wdt_cnt_q;
    logic [SUP_W-1:0]  sup_q;

    logic              t0cs;
    logic              psa;
    logic [PS_W-1:0]   ps;
    logic [PSC_W-1:0]  mask;

    logic              ext_edge_c;
    logic              src_tick_c;
    logic              base_tick_c;
    logic              wdt_clr_c;
    logic              psc_hit_c;
    logic              psc_clr_c;
    logic              psc_inc_c;
    logic              inc_c;
    logic              timeout_c;

    logic              tmr0_inc_d;
    logic              wdtmr_d;
    logic              sleeping_d;
    logic              wdt_rst_req_d;
    logic              wake_d;

    // OPTION field decode
    assign t0cs = option_q[OPT_T0CS];
    assign psa  = option_q[OPT_PSA];
    assign ps   = option_q[OPT_PS_MSB:OPT_PS_LSB];
    assign mask = psc_mask(ps, psa);

    t0cki_sync u_t0cki_sync (
        .clk      (clk),
        .rst      (rst),
        .pin      (t0cki),
        .fall_sel (option_q[OPT_T0SE]),
        .edge_c   (ext_edge_c)
    );

    // Internal source only runs while the core is executing; the external
    // pin keeps counting through sleep.
    assign src_tick_c  = t0cs ? ext_edge_c : (state_q == ST_RUN);
    assign base_tick_c = wdt_en && (wdt_cnt_q == WDT_MAX);
    assign wdt_clr_c   = CLRWDT | SLEEP;
    assign psc_hit_c   = (psc_q & mask) == mask;

    assign psc_clr_c = (option_wr && (option_data[OPT_PSA] != psa))
                     | (tmr0_wr & ~psa)
                     | (wdt_clr_c & psa);
    assign psc_inc_c = psa ? base_tick_c : src_tick_c;

    // TMR0 increment, masked in the write cycle and the two that follow
    assign inc_c = (psa ? src_tick_c : (src_tick_c & psc_hit_c))
                 & ~tmr0_wr & (sup_q == '0);

    // A coincident CLRWDT/SLEEP wins over the time-out
    assign timeout_c = base_tick_c & ~wdt_clr_c & (~psa | psc_hit_c);

    // OPTION register
    always_ff @(posedge clk) begin
        if (rst) begin
            option_q <= OPTION_RST;
        end else if (option_wr) begin
            option_q <= option_data;
        end
    end

    // Shared prescaler; any clear takes precedence over a count
    always_ff @(posedge clk) begin
        if (rst || psc_clr_c) begin
            psc_q <= '0;
        end else if (psc_inc_c) begin
            psc_q <= psc_q + PSC_W'(1);
        end
    end

    // Watchdog base counter, parked at zero when the fuse is off
    always_ff @(posedge clk) begin
        if (rst || !wdt_en || wdt_clr_c || (wdt_cnt_q == WDT_MAX)) begin
            wdt_cnt_q <= '0;
        end else begin
            wdt_cnt_q <= wdt_cnt_q + WDT_W'(1);
        end
    end

    // Post-write suppression countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            sup_q <= '0;
        end else if (tmr0_wr) begin
            sup_q <= SUP_W'(SUP_CYC);
        end else if (sup_q != '0) begin
            sup_q <= sup_q - SUP_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_nx;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            ST_RUN:  if (SLEEP)     state_nx = ST_SLP;
            ST_SLP:  if (timeout_c) state_nx = ST_WAKE;
            ST_WAKE: state_nx = ST_RUN;
            default: state_nx = ST_RUN;
        endcase
    end

    // FSM output decode (registered below)
    always_comb begin
        tmr0_inc_d    = inc_c;
        wdtmr_d       = timeout_c;
        wdt_rst_req_d = 1'b0;
        wake_d        = 1'b0;
        sleeping_d    = (state_nx != ST_RUN);
        unique case (state_q)
            ST_RUN:  wdt_rst_req_d = timeout_c;
            ST_SLP:  wake_d        = timeout_c;
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr0_inc    <= 1'b0;
            wdtmr       <= 1'b0;
            sleeping    <= 1'b0;
            wdt_rst_req <= 1'b0;
            wake        <= 1'b0;
        end else begin
            tmr0_inc    <= tmr0_inc_d;
            wdtmr       <= wdtmr_d;
            sleeping    <= sleeping_d;
            wdt_rst_req <= wdt_rst_req_d;
            wake        <= wake_d;
        end
    end

endmodule : tmr0_wdt_ctrl
